dpram_be_pipe: RTL
==================

// Module: dpram_be_pipe
// PURPOSE
//  Next-generation simple dual-port RAM: port A write-only, port B read-only, one shared clock.
//  Adds per-byte write enables, explicit read enable with a matching valid strobe,
//  and a selectable 1- or 2-cycle read latency.
//  Optionally forwards write data to a read of the same address in the same cycle.
//  Used as the generic buffer and scratch memory behind DMA and pcore data paths.
// PARAMETERS
//  numwords   256  depth in words
//  widthad    8    address width; numwords <= 2**widthad
//  width      32   data width, both ports
//  byte_width 8    bits per byte lane; width % byte_width == 0
//  read_lat   1    read latency in cycles; legal values 1 or 2
// PORTS
//  clock      in   1                 single clock; all logic on the rising edge
//  reset      in   1                 asynchronous, active-high; clears output and pipeline registers only
//  wren_a     in   1                 write request, port A
//  byteena_a  in   width/byte_width  byte-lane write mask; bit i covers data_a[i*byte_width +: byte_width]
//  address_a  in   widthad           write address
//  data_a     in   width             write data
//  rden_b     in   1                 read request, port B
//  address_b  in   widthad           read address
//  q_b        out  width             read data
//  q_valid_b  out  1                 high for 1 cycle when q_b carries data for a request
// BEHAVIOUR
//  Reset:
//  - q_b = 0 and q_valid_b = 0; all in-flight read stages are cleared.
//  - Memory contents are not cleared; their value after power-up is undefined.
//  Write:
//  - At an edge with wren_a=1, lanes with byteena_a[i]=1 take data_a; all other lanes keep their value.
//  - wren_a=1 with byteena_a=0 leaves memory unchanged.
//  Read:
//  - rden_b=1 sampled at edge N -> q_b valid and q_valid_b=1 after edge N+read_lat.
//  - Full throughput: one read per cycle, no stalls, no backpressure.
//  - Back-to-back requests give consecutive valid cycles.
//  - With no valid output, q_b holds its last value (no_change); it is not zeroed.
//  read_lat=2 adds one output register stage. Data and valid travel in lockstep.
//  Addresses >= numwords:
//  - writes are ignored;
//  - reads return undefined data, and q_valid_b still asserts.
//  Read/write same address, same edge:
//  - see CONFIGURATION.
//  - A write at edge N+1 never changes data already captured for a read at edge N.
//  Reset mid-operation:
//  - reads in flight when reset asserts are discarded; q_valid_b never rises for them.
//  - Requests issued while reset is high are ignored.
//  Elaboration checks (simulation $error):
//  - read_lat not in {1,2};
//  - width not a multiple of byte_width;
//  - numwords > 2**widthad.
// CONFIGURATION
//  Macro DPRAM_BE_PIPE_WR_BYPASS_EN.
//  - Defined: a collision returns new data. Written lanes come from data_a; unwritten lanes
//    come from memory. Needs a comparator and merge mux on the read path.
//  - Undefined: a collision returns old data (read-first). No forwarding logic is built.
//  Non-colliding behaviour is identical either way.
// TESTING
//  1 Assert reset with rden_b=1 -> q_b=0, q_valid_b=0 throughout reset.
//  2 read_lat=1: write 0x11223344 to addr 5, byteena=4'hF; read addr 5 next cycle
//    -> q_b=0x11223344 after one edge, q_valid_b high exactly one cycle.
//  3 byteena_a=4'b0010, data 0xAABBCCDD to addr 5; then read addr 5 -> q_b=0x1122CC44.
//  4 Addr 7 holds 0; same edge: write 0xFFFFFFFF byteena 4'b0011 and read addr 7
//    -> q_b=0x00000000 without the macro, 0x0000FFFF with it;
//    a later read returns 0x0000FFFF in both builds.
//  5 read_lat=2: reads to addr 5,6,7 on three consecutive edges
//    -> q_valid_b high for 3 consecutive cycles starting 2 edges after the first read, data in order.
//  6 read_lat=2: read addr 5, assert reset the next cycle
//    -> q_valid_b stays 0 and q_b=0; after reset, a new read of addr 5 returns 0x1122CC44.

Source files
------------

// File: rtl/dpram_be_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_be_pipe
//  Purpose  : Simple dual-port RAM on one clock. Port A is write-only with
//             per-byte-lane enables. Port B is read-only with a read enable
//             and a matching valid strobe. Read latency is 1 or 2 cycles.
//  Ports    : clock      - single clock, rising edge
//             reset      - asynchronous active-high; clears read pipeline only
//             wren_a     - write request
//             byteena_a  - byte-lane write mask (bit i -> lane i)
//             address_a  - write address
//             data_a     - write data
//             rden_b     - read request
//             address_b  - read address
//             q_b        - read data (holds last value between reads)
//             q_valid_b  - one-cycle strobe per completed read
//  Options  : DPRAM_BE_PIPE_WR_BYPASS_EN - when defined, a same-edge
//             read/write to one address returns the newly written lanes.
//             When undefined, the read returns the old contents.
//  Revision : 1.0 - initial release
// ============================================================================
module dpram_be_pipe #(
   parameter int NUMWORDS   = 256,
   parameter int WIDTHAD    = 8,
   parameter int WIDTH      = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int READ_LAT   = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          wren_a,
   input  logic [WIDTH/BYTE_WIDTH-1:0]   byteena_a,
   input  logic [WIDTHAD-1:0]            address_a,
   input  logic [WIDTH-1:0]              data_a,
   input  logic                          rden_b,
   input  logic [WIDTHAD-1:0]            address_b,
   output logic [WIDTH-1:0]              q_b,
   output logic                          q_valid_b
);

   localparam int                 c_lanes    = WIDTH / BYTE_WIDTH;
   localparam logic [WIDTHAD:0]   c_numwords = (WIDTHAD + 1)'(NUMWORDS);

   // Elaboration-time parameter sanity checks
   if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_chk_lat
      $error("dpram_be_pipe: READ_LAT must be 1 or 2");
   end
   if ((WIDTH % BYTE_WIDTH) != 0) begin : g_chk_width
      $error("dpram_be_pipe: WIDTH must be a multiple of BYTE_WIDTH");
   end
   if (NUMWORDS > (1 << WIDTHAD)) begin : g_chk_depth
      $error("dpram_be_pipe: NUMWORDS exceeds 2**WIDTHAD");
   end

   logic [WIDTH-1:0] mem [0:NUMWORDS-1];

   logic             w_wr_in_range;
   logic             w_rd_in_range;
   logic [WIDTH-1:0] w_mem_rd;
   logic [WIDTH-1:0] w_rd_data;
   logic [WIDTH-1:0] r_q1;
   logic             r_v1;

   assign w_wr_in_range = ({1'b0, address_a} < c_numwords);
   assign w_rd_in_range = ({1'b0, address_b} < c_numwords);

   // Memory array has no reset: contents survive reset and power up undefined.
   always_ff @(posedge clock) begin
      if (wren_a && w_wr_in_range) begin
         for (int i = 0; i < c_lanes; i++) begin
            if (byteena_a[i]) begin
               mem[address_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // Out-of-range reads return an arbitrary value; zero is used here.
   assign w_mem_rd = w_rd_in_range ? mem[address_b] : '0;

`ifdef DPRAM_BE_PIPE_WR_BYPASS_EN
   // Same-edge collision: written lanes are forwarded from data_a, the rest
   // come from the array, so the read sees the post-write word.
   always_comb begin
      w_rd_data = w_mem_rd;
      if (wren_a && w_wr_in_range && (address_a == address_b)) begin
         for (int i = 0; i < c_lanes; i++) begin
            if (byteena_a[i]) begin
               w_rd_data[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end
`else
   // Read-first: the array is sampled before this edge's write lands.
   assign w_rd_data = w_mem_rd;
`endif

   // First read stage; data only loads on a request so q_b holds otherwise.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_q1 <= '0;
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= rden_b;
         if (rden_b) begin
            r_q1 <= w_rd_data;
         end
      end
   end

   if (READ_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] r_q2;
      logic             r_v2;

      // Extra output stage; data and valid advance together.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r_q2 <= '0;
            r_v2 <= 1'b0;
         end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
               r_q2 <= r_q1;
            end
         end
      end

      assign q_b       = r_q2;
      assign q_valid_b = r_v2;
   end else begin : g_lat1
      assign q_b       = r_q1;
      assign q_valid_b = r_v1;
   end

endmodule
`default_nettype wire
